// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : fetch/data requester and memory-port signal bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        busy;

  // Arbiter side
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
    output i_ack, d_ack, rdata, err, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester/memory side
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
    input  i_ack, d_ack, rdata, err, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin fetch/data arbiter for a single memory port
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_data_q, grant_data_d;   // latched winner is the data port
  logic        last_data_q, last_data_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        win_data;

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    last_data_d  = last_data_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    win_data     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // On a tie the port that did not win last time takes the grant
          win_data     = bus.d_req && (!bus.i_req || !last_data_q);
          grant_data_d = win_data;
          last_data_d  = win_data;
          addr_d       = win_data ? bus.d_addr  : bus.i_addr;
          we_d         = win_data && bus.d_we;
          wdata_d      = win_data ? bus.d_wdata : 32'h0;
          mem_en_d     = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 8'h00;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_done) begin
          rdata_d = we_q ? 32'h0 : bus.mem_rdata;
          err_d   = 1'b0;
          i_ack_d = !grant_data_q;
          d_ack_d = grant_data_q;
          state_d = RESP;
        end else if (cnt_q == LAST_CNT) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          i_ack_d = !grant_data_q;
          d_ack_d = grant_data_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_data_q <= 1'b0;
      last_data_q  <= 1'b1;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      cnt_q        <= 8'h00;
      mem_en_q     <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      last_data_q  <= last_data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : vector table, corner sequences and randomized traffic
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit model_last_d;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;      // WAIT-cycle index at which mem_done is pulsed
    logic [31:0] mrd;
    int          exp_ack;    // ack cycle, request sampled in cycle 0
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_total++;
    $display("FAIL %s: event count or presence differs from required", name);
  endtask

  // Entered at a negedge in an IDLE cycle with the requests already driven.
  // Returns at the negedge of the IDLE cycle that follows the ack.
  task automatic serve(input bit exp_d, input bit exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input int delay, input logic [31:0] mrd,
                       input int exp_ack, input logic [31:0] exp_rd, input bit exp_err,
                       input string tag);
    int en_cyc;
    int ack_cyc;
    bit fin;
    en_cyc  = -1;
    ack_cyc = -1;
    fin     = 1'b0;
    check({tag, " busy_at_start"}, 32'(bus.busy), 32'd0);
    for (int k = 1; k <= 40 && !fin; k++) begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (bus.mem_en) begin
        if (en_cyc >= 0) fail_event({tag, " single_mem_en"});
        else begin
          en_cyc = k;
          check({tag, " mem_en_cycle"}, 32'(k), 32'd1);
          check({tag, " mem_we"},    32'(bus.mem_we), 32'(exp_we));
          check({tag, " mem_addr"},  bus.mem_addr,  exp_addr);
          check({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        if (ack_cyc >= 0) fail_event({tag, " single_ack"});
        else begin
          ack_cyc = k;
          check({tag, " ack_cycle"}, 32'(k), 32'(exp_ack));
          check({tag, " i_ack"}, 32'(bus.i_ack), 32'(!exp_d));
          check({tag, " d_ack"}, 32'(bus.d_ack), 32'(exp_d));
          check({tag, " rdata"}, bus.rdata, exp_rd);
          check({tag, " err"},   32'(bus.err), 32'(exp_err));
          if (bus.d_ack) bus.d_req = 1'b0;
          else           bus.i_req = 1'b0;
        end
      end
      if (en_cyc >= 0 && k == en_cyc + 1 + delay) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = mrd;
      end
      if (ack_cyc >= 0 && k == ack_cyc + 1) begin
        check({tag, " busy_after_ack"}, 32'(bus.busy), 32'd0);
        fin = 1'b1;
      end
    end
    if (en_cyc < 0)  fail_event({tag, " mem_en_missing"});
    if (ack_cyc < 0) fail_event({tag, " ack_missing"});
    model_last_d = exp_d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn         = 1'b0;
    bus.i_req    = 1'b0;
    bus.d_req    = 1'b0;
    bus.mem_done = 1'b0;
    @(negedge clk);
    rstn         = 1'b1;
    model_last_d = 1'b1;
    @(negedge clk);
  endtask

  vec_t        vt[7];
  bit          pi, pd, w, e_err;
  logic        dwe;
  logic [31:0] ia, da, dw, mrd, e_rd;
  int          dly, e_ack;

  initial begin
    vt[0] = '{0, 0, 32'h0000_0100, 32'h0,         0,  32'hDEADBEEF, 3, 32'hDEADBEEF, 0, 0, 32'h0};
    vt[1] = '{1, 1, 32'h0000_0040, 32'h1234_5678, 2,  32'hAAAA5555, 5, 32'h0,        0, 1, 32'h1234_5678};
    vt[2] = '{1, 0, 32'h0000_0080, 32'hCAFE_F00D, 1,  32'h0BADF00D, 4, 32'h0BADF00D, 0, 0, 32'hCAFE_F00D};
    vt[3] = '{0, 0, 32'h0000_0104, 32'h0,         3,  32'h13579BDF, 6, 32'h13579BDF, 0, 0, 32'h0};
    vt[4] = '{0, 0, 32'h0000_0108, 32'h0,         40, 32'h11111111, 6, 32'h0,        1, 0, 32'h0};
    vt[5] = '{1, 1, 32'h0000_0044, 32'h55AA_55AA, 4,  32'hFFFFFFFF, 6, 32'h0,        1, 1, 32'h55AA_55AA};
    vt[6] = '{1, 0, 32'h0000_0048, 32'h0,         5,  32'h77777777, 6, 32'h0,        1, 0, 32'h0};

    rstn          = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'h0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h0;
    bus.d_wdata   = 32'hFFFF_FFFF;
    bus.mem_rdata = 32'h0;
    bus.mem_done  = 1'b0;
    model_last_d  = 1'b1;

    @(negedge clk);
    check("rst mem_en",    32'(bus.mem_en), 32'd0);
    check("rst mem_we",    32'(bus.mem_we), 32'd0);
    check("rst acks",      32'({bus.i_ack, bus.d_ack}), 32'd0);
    check("rst err",       32'(bus.err),  32'd0);
    check("rst busy",      32'(bus.busy), 32'd0);
    check("rst mem_addr",  bus.mem_addr,  32'h0);
    check("rst mem_wdata", bus.mem_wdata, 32'h0);
    check("rst rdata",     bus.rdata,     32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (vt[v].is_d) begin
        bus.d_req   = 1'b1;
        bus.d_we    = vt[v].we;
        bus.d_addr  = vt[v].addr;
        bus.d_wdata = vt[v].wdata;
      end else begin
        bus.i_req  = 1'b1;
        bus.i_addr = vt[v].addr;
      end
      serve(vt[v].is_d, vt[v].exp_we, vt[v].addr, vt[v].exp_wdata, vt[v].delay, vt[v].mrd,
            vt[v].exp_ack, vt[v].exp_rd, vt[v].exp_err, $sformatf("vec%0d", v));
    end

    // Spurious mem_done while idle
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("spurious c%0d", c),
            32'({bus.i_ack, bus.d_ack, bus.busy, bus.mem_en}), 32'd0);
      bus.mem_done  = (c < 3);
      bus.mem_rdata = 32'h5A5A_5A5A;
    end

    // Both requesters held: grants alternate I, D, I, D from reset
    do_reset();
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_1000;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_2000;
    bus.d_wdata = 32'h0;
    for (int n = 0; n < 4; n++) begin
      w = n[0];
      serve(w, 1'b0, w ? bus.d_addr : bus.i_addr, 32'h0, 0, 32'hA000_0000 + 32'(n),
            3, 32'hA000_0000 + 32'(n), 1'b0, $sformatf("tie%0d", n));
      if (w) begin
        bus.d_req  = 1'b1;
        bus.d_addr = bus.d_addr + 32'd4;
      end else begin
        bus.i_req  = 1'b1;
        bus.i_addr = bus.i_addr + 32'd4;
      end
    end

    // Reset in the middle of WAIT
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0200;
    @(negedge clk);
    check("midrst mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge clk);
    check("midrst busy_wait", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst busy_now", 32'(bus.busy), 32'd0);
    check("midrst acks",     32'({bus.i_ack, bus.d_ack}), 32'd0);
    check("midrst mem_addr", bus.mem_addr, 32'h0);
    bus.i_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_last_d = 1'b1;
    @(negedge clk);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'h0000_0099;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      check($sformatf("late_done c%0d", c), 32'({bus.i_ack, bus.d_ack, bus.busy}), 32'd0);
    end
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0300;
    serve(1'b0, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h3333_4444, 4, 32'h3333_4444, 1'b0, "after_rst");

    // Randomized traffic against the round-robin / timeout model
    pi = 1'b0;
    pd = 1'b0;
    for (int r = 0; r < 40; r++) begin
      if (!pi && ($urandom_range(0, 1) == 1 || !pd)) begin
        pi         = 1'b1;
        ia         = $urandom;
        bus.i_req  = 1'b1;
        bus.i_addr = ia;
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd          = 1'b1;
        dwe         = 1'($urandom_range(0, 1));
        da          = $urandom;
        dw          = $urandom;
        bus.d_req   = 1'b1;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dw;
      end
      w     = (pi && pd) ? !model_last_d : pd;
      dly   = $urandom_range(0, 6);
      mrd   = $urandom;
      e_err = (dly >= TO);
      e_ack = 3 + (e_err ? TO - 1 : dly);
      e_rd  = e_err ? 32'h0 : ((w && dwe) ? 32'h0 : mrd);
      serve(w, w && dwe, w ? da : ia, w ? dw : 32'h0, dly, mrd, e_ack, e_rd, e_err,
            $sformatf("rnd%0d", r));
      if (w) pd = 1'b0;
      else   pi = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
